// File: rtl/block_copy_dma_pkg.sv
// Shared constants and state encoding for the block-copy DMA engine.
package block_copy_dma_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LEN_W = 8;
    localparam int DEFAULT_MEM_DEPTH = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } dmaState_t;

endpackage

// File: rtl/block_copy_dma_if.sv
// Control and data-memory bus of the block-copy DMA; master is the DMA side.
interface block_copy_dma_if;
    import block_copy_dma_pkg::*;

    logic              start;
    logic [ADDR_W-1:0] srcAddr;
    logic [ADDR_W-1:0] dstAddr;
    logic [LEN_W-1:0]  length;
    logic              busy;
    logic              done;
    logic              error;
    logic [LEN_W-1:0]  wordsCopied;
    logic [ADDR_W-1:0] memAddress;
    logic [DATA_W-1:0] memWriteData;
    logic              memWrite;
    logic              memRead;
    logic [DATA_W-1:0] memReadData;

    modport master (
        input  start, srcAddr, dstAddr, length, memReadData,
        output busy, done, error, wordsCopied,
        output memAddress, memWriteData, memWrite, memRead
    );

    modport slave (
        output start, srcAddr, dstAddr, length, memReadData,
        input  busy, done, error, wordsCopied,
        input  memAddress, memWriteData, memWrite, memRead
    );

endinterface

// File: rtl/block_copy_dma.sv
// Word-at-a-time memory-to-memory copy engine: alternating READ/WRITE cycles,
// range-checked at start, with all memory-side outputs decoded from state.
module block_copy_dma
    import block_copy_dma_pkg::*;
#(
    parameter int MEM_DEPTH = DEFAULT_MEM_DEPTH
) (
    input logic              CLK,
    input logic              reset,
    block_copy_dma_if.master bus
);

    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(MEM_DEPTH);

    dmaState_t         state;
    dmaState_t         stateNext;
    logic [ADDR_W-1:0] srcPtr;
    logic [ADDR_W-1:0] dstPtr;
    logic [LEN_W-1:0]  lenReg;
    logic [LEN_W-1:0]  count;
    logic [DATA_W-1:0] dataReg;
    logic              errorReg;
    logic [ADDR_W:0]   srcEnd;
    logic [ADDR_W:0]   dstEnd;
    logic              rangeOk;

    // One extra bit so that an address near 2^32 cannot wrap into range.
    always_comb begin
        srcEnd  = {1'b0, bus.srcAddr} + {{(ADDR_W + 1 - LEN_W){1'b0}}, bus.length};
        dstEnd  = {1'b0, bus.dstAddr} + {{(ADDR_W + 1 - LEN_W){1'b0}}, bus.length};
        rangeOk = (srcEnd <= DEPTH_EXT) && (dstEnd <= DEPTH_EXT);
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    stateNext = (!rangeOk || bus.length == '0) ? DONE : READ;
                end
            end
            READ:    stateNext = WRITE;
            WRITE:   stateNext = (count + 8'd1 == lenReg) ? DONE : READ;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            srcPtr   <= '0;
            dstPtr   <= '0;
            lenReg   <= '0;
            count    <= '0;
            dataReg  <= '0;
            errorReg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        count    <= '0;
                        errorReg <= !rangeOk;
                        // An illegal request leaves the previous parameters untouched.
                        if (rangeOk) begin
                            srcPtr <= bus.srcAddr;
                            dstPtr <= bus.dstAddr;
                            lenReg <= bus.length;
                        end
                    end
                end
                READ: dataReg <= bus.memReadData;
                WRITE: begin
                    srcPtr <= srcPtr + 32'd1;
                    dstPtr <= dstPtr + 32'd1;
                    count  <= count + 8'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.busy         = 1'b0;
        bus.done         = 1'b0;
        bus.memRead      = 1'b0;
        bus.memWrite     = 1'b0;
        bus.memAddress   = '0;
        bus.memWriteData = '0;
        case (state)
            READ: begin
                bus.busy       = 1'b1;
                bus.memRead    = 1'b1;
                bus.memAddress = srcPtr;
            end
            WRITE: begin
                bus.busy         = 1'b1;
                bus.memWrite     = 1'b1;
                bus.memAddress   = dstPtr;
                bus.memWriteData = dataReg;
            end
            DONE:    bus.done = 1'b1;
            default: ;
        endcase
        bus.error       = errorReg;
        bus.wordsCopied = count;
    end

endmodule

// File: tb/tb_block_copy_dma.sv
// Directed and randomized bench for block_copy_dma against an array-level copy model.
module tb_block_copy_dma;

    localparam int DEPTH = 128;

    logic clk;
    logic reset;
    block_copy_dma_if bus();

    block_copy_dma #(.MEM_DEPTH(DEPTH)) dut (
        .CLK   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem     [DEPTH];
    logic [31:0] refMem  [DEPTH];
    logic [31:0] seedMem [DEPTH];
    logic        loadReq;
    int          writes;
    int          reads;
    int          dones;
    int          checks;
    int          errors;

    always_comb begin
        if (bus.memAddress < 32'(DEPTH)) bus.memReadData = mem[bus.memAddress[6:0]];
        else bus.memReadData = 32'hDEAD_BEEF;
    end

    // Memory model: commits on the falling edge; also counts bus activity.
    initial begin
        writes = 0;
        reads  = 0;
        dones  = 0;
    end
    always @(negedge clk) begin
        if (loadReq) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= seedMem[i];
        end else if (bus.memWrite) begin
            if (bus.memAddress < 32'(DEPTH)) mem[bus.memAddress[6:0]] <= bus.memWriteData;
        end
        if (bus.memWrite) writes <= writes + 1;
        if (bus.memRead) reads <= reads + 1;
        if (bus.done) dones <= dones + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int memDiff();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== refMem[i]) n++;
        return n;
    endfunction

    task automatic loadMem();
        for (int i = 0; i < DEPTH; i++) refMem[i] = seedMem[i];
        loadReq = 1'b1;
        @(posedge clk); #1;
        loadReq = 1'b0;
    endtask

    task automatic runCopy(input string tag, input logic [31:0] src, input logic [31:0] dst,
                           input logic [7:0] len, input int glitchAt);
        logic legal;
        int   expLat;
        int   lat;
        int   w0, r0, d0;
        legal  = (longint'(src) + longint'(len) <= DEPTH) && (longint'(dst) + longint'(len) <= DEPTH);
        expLat = (legal && len != 0) ? 2 * int'(len) : 0;
        if (legal) for (int i = 0; i < int'(len); i++) refMem[dst + i] = refMem[src + i];
        w0 = writes;
        r0 = reads;
        d0 = dones;
        bus.start   = 1'b1;
        bus.srcAddr = src;
        bus.dstAddr = dst;
        bus.length  = len;
        @(posedge clk); #1;
        bus.start   = 1'b0;
        bus.srcAddr = $urandom;
        bus.dstAddr = $urandom;
        bus.length  = 8'($urandom);
        lat = -1;
        for (int k = 0; k < 600; k++) begin
            if (bus.done) begin
                lat = k;
                break;
            end
            if (k == glitchAt) begin
                bus.start   = 1'b1;
                bus.srcAddr = 32'($urandom_range(0, 60));
                bus.dstAddr = 32'($urandom_range(0, 60));
                bus.length  = 8'($urandom_range(1, 8));
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        check({tag, "_latency"}, 32'(lat), 32'(expLat));
        check({tag, "_error"}, {31'd0, bus.error}, {31'd0, !legal});
        check({tag, "_words"}, {24'd0, bus.wordsCopied}, legal ? {24'd0, len} : 32'd0);
        @(posedge clk); #1;
        check({tag, "_donePulse"}, {31'd0, bus.done}, 32'd0);
        check({tag, "_idleBusy"}, {31'd0, bus.busy}, 32'd0);
        check({tag, "_writes"}, 32'(writes - w0), legal ? {24'd0, len} : 32'd0);
        check({tag, "_reads"}, 32'(reads - r0), legal ? {24'd0, len} : 32'd0);
        check({tag, "_doneCount"}, 32'(dones - d0), 32'd1);
        check({tag, "_mem"}, 32'(memDiff()), 32'd0);
    endtask

    initial begin
        int w0, d0;
        logic [31:0] src, dst;
        logic [7:0]  len;
        int          glitch;
        checks      = 0;
        errors      = 0;
        loadReq     = 1'b0;
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.srcAddr = '0;
        bus.dstAddr = '0;
        bus.length  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_error", {31'd0, bus.error}, 32'd0);
        check("rst_memRead", {31'd0, bus.memRead}, 32'd0);
        check("rst_memWrite", {31'd0, bus.memWrite}, 32'd0);
        check("rst_words", {24'd0, bus.wordsCopied}, 32'd0);
        check("rst_addr", bus.memAddress, 32'd0);
        check("rst_wdata", bus.memWriteData, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < DEPTH; i++) seedMem[i] = 32'(i) + 32'h100;
        loadMem();

        runCopy("basic", 32'd0, 32'd64, 8'd4, -1);
        check("basic_w64", mem[64], 32'h100);
        check("basic_w67", mem[67], 32'h103);

        runCopy("zeroLen", 32'd5, 32'd6, 8'd0, -1);
        runCopy("illegal", 32'd120, 32'd0, 8'd10, -1);
        runCopy("wrapSrc", 32'hFFFF_FFFE, 32'd0, 8'd4, -1);
        runCopy("fullMem", 32'd0, 32'd0, 8'd128, -1);

        seedMem[10] = 32'hA;
        loadMem();
        runCopy("overlap", 32'd10, 32'd11, 8'd3, -1);
        check("overlap_w13", mem[13], 32'hA);

        runCopy("midStart", 32'd20, 32'd40, 8'd5, 3);

        // Reset lands in the second WRITE cycle of a 4-word copy.
        w0 = writes;
        d0 = dones;
        bus.start   = 1'b1;
        bus.srcAddr = 32'd0;
        bus.dstAddr = 32'd80;
        bus.length  = 8'd4;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rstWr_inWrite", {31'd0, bus.memWrite}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        refMem[80] = refMem[0];
        refMem[81] = refMem[1];
        check("rstWr_memWrite", {31'd0, bus.memWrite}, 32'd0);
        check("rstWr_memRead", {31'd0, bus.memRead}, 32'd0);
        check("rstWr_busy", {31'd0, bus.busy}, 32'd0);
        check("rstWr_addr", bus.memAddress, 32'd0);
        check("rstWr_words", {24'd0, bus.wordsCopied}, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check("rstWr_writes", 32'(writes - w0), 32'd2);
        check("rstWr_noDone", 32'(dones - d0), 32'd0);
        check("rstWr_mem", 32'(memDiff()), 32'd0);

        for (int i = 0; i < DEPTH; i++) seedMem[i] = $urandom;
        loadMem();
        for (int n = 0; n < 16; n++) begin
            len = 8'($urandom_range(0, 16));
            src = 32'($urandom_range(0, 127));
            dst = 32'($urandom_range(0, 127));
            if ($urandom_range(0, 5) == 0) src = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) begin
                if (src < 32'(DEPTH) && src + 32'(len) > 32'(DEPTH)) src = 32'(DEPTH) - 32'(len);
                if (dst + 32'(len) > 32'(DEPTH)) dst = 32'(DEPTH) - 32'(len);
            end
            glitch = (len >= 2) ? $urandom_range(1, 2 * int'(len) - 1) : -1;
            runCopy($sformatf("rand%0d", n), src, dst, len, glitch);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/block_copy_dma.md
BLOCK_COPY_DMA -- requirements
Module: block_copy_dma

Interface
REQ-001 Parameter MEM_DEPTH, default 128: number of 32-bit words in the attached data memory; word addresses run 0..MEM_DEPTH-1.
REQ-002 CLK  input  1  system clock; all state changes on posedge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on posedge CLK.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 srcAddr  input  32  first source word address, captured at start.
REQ-006 dstAddr  input  32  first destination word address, captured at start.
REQ-007 length  input  8  words to copy, 0..MEM_DEPTH, captured at start.
REQ-008 busy  output  1  high in READ and WRITE states.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 error  output  1  sticky range-error flag; cleared by the next accepted start.
REQ-011 wordsCopied  output  8  count of words written in the current or last transfer.
REQ-012 memAddress  output  32  word address to the data memory.
REQ-013 memWriteData  output  32  write data to the data memory.
REQ-014 memWrite  output  1  write strobe; the memory commits on negedge CLK while high.
REQ-015 memRead  output  1  read enable; memory returns data combinationally.
REQ-016 memReadData  input  32  read data from the data memory.

Function
REQ-017 FSM states: IDLE, READ, WRITE, DONE; all memory-side outputs shall be Moore outputs decoded from state and registers.
REQ-018 In IDLE with start=1 and a legal range, the block shall capture srcAddr/dstAddr/length, clear wordsCopied and error, and enter READ (or DONE directly if length=0).
REQ-019 A range is illegal when srcAddr+length > MEM_DEPTH or dstAddr+length > MEM_DEPTH, computed at 33-bit width with no wrap; on illegal start the block shall set error, issue no memory access, and enter DONE.
REQ-020 READ: memRead=1, memWrite=0, memAddress=src pointer; at the next posedge memReadData shall be latched into a data register and the state shall become WRITE.
REQ-021 WRITE: memWrite=1, memRead=0, memAddress=dst pointer, memWriteData=data register; at the next posedge both pointers increment by 1 and wordsCopied increments by 1.
REQ-022 After WRITE, if wordsCopied (post-increment) equals length the state shall become DONE, otherwise READ.
REQ-023 DONE: done=1 for exactly one cycle, then IDLE.
REQ-024 Timing: with start accepted at edge t and N>0, done shall be high in the cycle after edge t+2N; with N=0 or illegal range, after edge t.
REQ-025 Words shall be copied in ascending address order; overlapping ranges with dst>src shall propagate source words forward. This is defined behaviour, not an error.
REQ-026 start while not IDLE shall be ignored with no effect on the captured parameters.
REQ-027 In IDLE and DONE: memRead=0, memWrite=0, memAddress=0, memWriteData=0.

Reset
REQ-028 On reset the state shall be IDLE and busy, done, error, memRead and memWrite shall be 0; wordsCopied, memAddress, memWriteData and all internal registers shall be 0.
REQ-029 A reset asserted in a WRITE cycle shall not suppress that cycle's negedge write. No further access shall follow, and the transfer shall be abandoned without a done pulse.

Structure
REQ-030 A shared package or include file shall hold MEM_DEPTH, the state encodings and the address width of 32.
REQ-031 The design shall be a single module with no sub-modules. The pointers, counter and data register shall live in one sequential block, with the output decode in a separate combinational block.

Verification
REQ-032 Memory preload mem[i]=i+0x100; start with src=0, dst=64, len=4 -> mem[64..67]=0x100..0x103, done 8 cycles after the start edge, wordsCopied=4.
REQ-033 len=0, src=5, dst=6 -> done in the cycle after the start edge; memWrite never high; memory unchanged.
REQ-034 src=120, dst=0, len=10 -> error=1 and done pulse; memRead and memWrite never high; memory unchanged.
REQ-035 Overlap src=10, dst=11, len=3, mem[10]=0xA -> mem[11..13]=0xA.
REQ-036 Assert reset in the second WRITE cycle of a len=4 copy -> exactly 2 words written, outputs 0 on the next cycle, no done pulse.
REQ-037 Pulse start mid-transfer with different parameters -> ignored; the original copy completes unchanged.
